// File: rtl/cond_check_unit.sv
// ARM condition-check unit: NZCV status register, NUM_CH parallel condition queries
// and an IT-style predication sequencer. Optional macro COND_FWD_EN forwards sr_in into evaluation.
module cond_check_unit #(
    parameter int NUM_CH = 2,
    parameter int PIPE   = 0,
    parameter int IT_MAX = 4,
    localparam int LEN_W = $clog2(IT_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sr_we,
    input  logic [3:0]            sr_in,
    output logic [3:0]            sr_o,
    input  logic [NUM_CH-1:0]     q_valid_i,
    input  logic [4*NUM_CH-1:0]   q_cond_i,
    output logic [NUM_CH-1:0]     q_valid_o,
    output logic [NUM_CH-1:0]     q_pass_o,
    input  logic                  it_start,
    input  logic [3:0]            it_cond,
    input  logic [LEN_W-1:0]      it_len,
    input  logic [IT_MAX-1:0]     it_mask,
    input  logic                  it_step,
    input  logic                  it_flush,
    output logic                  it_active_o,
    output logic                  it_pass_o,
    output logic [LEN_W-1:0]      it_remain_o
);

    localparam int MASK_W = 1 << LEN_W;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = c;
            4'b0011: r = !c;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = c & !z;
            4'b1001: r = !c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Status register
    logic [3:0] sr_q, sr_d;
    logic [3:0] eval_sr;

    always_comb begin
        sr_d = sr_we ? sr_in : sr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= 4'b0000;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr_o = sr_q;

    always_comb begin
`ifdef COND_FWD_EN
        eval_sr = sr_we ? sr_in : sr_q;
`else
        eval_sr = sr_q;
`endif
    end

    // Query channels
    logic [NUM_CH-1:0] pass_c;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign pass_c[gi] = q_valid_i[gi] & eval_cond(q_cond_i[4*gi +: 4], eval_sr);
        end

        if (PIPE == 1) begin : g_pipe
            logic [NUM_CH-1:0] q_valid_q, q_valid_d;
            logic [NUM_CH-1:0] q_pass_q, q_pass_d;

            always_comb begin
                q_valid_d = q_valid_i;
                q_pass_d  = pass_c;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q_valid_q <= '0;
                    q_pass_q  <= '0;
                end else begin
                    q_valid_q <= q_valid_d;
                    q_pass_q  <= q_pass_d;
                end
            end

            assign q_valid_o = q_valid_q;
            assign q_pass_o  = q_pass_q;
        end else begin : g_comb
            assign q_valid_o = q_valid_i;
            assign q_pass_o  = pass_c;
        end
    endgenerate

    // Predication sequencer
    state_t             state_q, state_d;
    logic [3:0]         cond_q, cond_d;
    logic [IT_MAX-1:0]  mask_q, mask_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [MASK_W-1:0]  mask_ext;
    logic [LEN_W-1:0]   remain;
    logic               start_ok;

    // Zero-padded so any idx_q value is a legal select
    assign mask_ext = {{(MASK_W - IT_MAX){1'b0}}, mask_q};
    assign remain   = len_q - idx_q;
    assign start_ok = it_start && (it_len != '0) && (it_len <= LEN_W'(IT_MAX));

    always_comb begin
        state_d     = state_q;
        cond_d      = cond_q;
        mask_d      = mask_q;
        len_d       = len_q;
        idx_d       = idx_q;
        it_active_o = 1'b0;
        it_pass_o   = 1'b1;
        it_remain_o = '0;

        if (state_q == ST_ACTIVE) begin
            it_active_o = 1'b1;
            it_remain_o = remain;
            it_pass_o   = ~(mask_ext[idx_q] ^ eval_cond(cond_q, eval_sr));
        end

        if (it_flush) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else if (start_ok) begin
            state_d = ST_ACTIVE;
            cond_d  = it_cond;
            mask_d  = it_mask;
            len_d   = it_len;
            idx_d   = '0;
        end else if (it_step && state_q == ST_ACTIVE) begin
            if (remain == LEN_W'(1)) begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cond_q  <= 4'b0000;
            mask_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cond_q  <= cond_d;
            mask_q  <= mask_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_cond_check_unit.sv
// Scoreboard bench for cond_check_unit: a combinational (PIPE=0) and a registered (PIPE=1)
// instance share stimulus; a negedge monitor pops expected query results per instance.
module tb_cond_check_unit;

    localparam int NUM_CH = 2;
    localparam int IT_MAX = 4;
    localparam int LEN_W  = $clog2(IT_MAX + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 sr_we;
    logic [3:0]           sr_in;
    logic [NUM_CH-1:0]    q_valid_i;
    logic [4*NUM_CH-1:0]  q_cond_i;
    logic                 it_start;
    logic [3:0]           it_cond;
    logic [LEN_W-1:0]     it_len;
    logic [IT_MAX-1:0]    it_mask;
    logic                 it_step;
    logic                 it_flush;

    logic [3:0]           sr_o0, sr_o1;
    logic [NUM_CH-1:0]    q_valid_o0, q_pass_o0, q_valid_o1, q_pass_o1;
    logic                 it_active_o0, it_pass_o0, it_active_o1, it_pass_o1;
    logic [LEN_W-1:0]     it_remain_o0, it_remain_o1;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];

    always #5 clk = ~clk;

    cond_check_unit #(.NUM_CH(NUM_CH), .PIPE(0), .IT_MAX(IT_MAX)) dut0 (
        .clk(clk), .rst_n(rst_n), .sr_we(sr_we), .sr_in(sr_in), .sr_o(sr_o0),
        .q_valid_i(q_valid_i), .q_cond_i(q_cond_i), .q_valid_o(q_valid_o0), .q_pass_o(q_pass_o0),
        .it_start(it_start), .it_cond(it_cond), .it_len(it_len), .it_mask(it_mask),
        .it_step(it_step), .it_flush(it_flush), .it_active_o(it_active_o0),
        .it_pass_o(it_pass_o0), .it_remain_o(it_remain_o0)
    );

    cond_check_unit #(.NUM_CH(NUM_CH), .PIPE(1), .IT_MAX(IT_MAX)) dut1 (
        .clk(clk), .rst_n(rst_n), .sr_we(sr_we), .sr_in(sr_in), .sr_o(sr_o1),
        .q_valid_i(q_valid_i), .q_cond_i(q_cond_i), .q_valid_o(q_valid_o1), .q_pass_o(q_pass_o1),
        .it_start(it_start), .it_cond(it_cond), .it_len(it_len), .it_mask(it_mask),
        .it_step(it_step), .it_flush(it_flush), .it_active_o(it_active_o1),
        .it_pass_o(it_pass_o1), .it_remain_o(it_remain_o1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sr(input logic [3:0] v);
        sr_we = 1'b1;
        sr_in = v;
        tick();
        sr_we = 1'b0;
    endtask

    // Drive one query cycle and queue its expected {valid, pass} for both instances
    task automatic query(input logic [1:0] v, input logic [3:0] c0, input logic [3:0] c1,
                         input logic [1:0] exp_pass);
        q_valid_i = v;
        q_cond_i  = {c1, c0};
        if (v != 2'b00) begin
            exp_q0.push_back({v, exp_pass});
            exp_q1.push_back({v, exp_pass});
        end
    endtask

    task automatic chk_seq(input string tag, input logic a, input logic [LEN_W-1:0] r, input logic p);
        check({tag, "_active0"}, 32'(it_active_o0), 32'(a));
        check({tag, "_remain0"}, 32'(it_remain_o0), 32'(r));
        check({tag, "_pass0"},   32'(it_pass_o0),   32'(p));
        check({tag, "_active1"}, 32'(it_active_o1), 32'(a));
        check({tag, "_remain1"}, 32'(it_remain_o1), 32'(r));
        check({tag, "_pass1"},   32'(it_pass_o1),   32'(p));
    endtask

    // Monitor: pop and compare whenever an instance presents a valid result
    always @(negedge clk) begin
        if (rst_n) begin
            check("dut0_invalid_pass", 32'(q_pass_o0 & ~q_valid_o0), 32'd0);
            check("dut1_invalid_pass", 32'(q_pass_o1 & ~q_valid_o1), 32'd0);
            if (q_valid_o0 != '0) begin
                if (exp_q0.size() == 0) begin
                    check("dut0_spurious_valid", 32'(q_valid_o0), 32'd0);
                end else begin
                    logic [3:0] e;
                    e = exp_q0.pop_front();
                    $display("txn dut0 valid=%b pass=%b exp_pass=%b", q_valid_o0, q_pass_o0, e[1:0]);
                    check("dut0_valid", 32'(q_valid_o0), 32'(e[3:2]));
                    check("dut0_pass",  32'(q_pass_o0),  32'(e[1:0]));
                end
            end
            if (q_valid_o1 != '0) begin
                if (exp_q1.size() == 0) begin
                    check("dut1_spurious_valid", 32'(q_valid_o1), 32'd0);
                end else begin
                    logic [3:0] e;
                    e = exp_q1.pop_front();
                    $display("txn dut1 valid=%b pass=%b exp_pass=%b", q_valid_o1, q_pass_o1, e[1:0]);
                    check("dut1_valid", 32'(q_valid_o1), 32'(e[3:2]));
                    check("dut1_pass",  32'(q_pass_o1),  32'(e[1:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] tab;
        logic        fwd_exp;
        // Expected pass per condition code for SR = 4'b0110 (Z=1, C=1), bit i = cond i
        tab = 16'h66A5;
`ifdef COND_FWD_EN
        fwd_exp = 1'b1;
`else
        fwd_exp = 1'b0;
`endif

        rst_n = 1'b0; sr_we = 1'b0; sr_in = 4'h0;
        q_valid_i = '0; q_cond_i = '0;
        it_start = 1'b0; it_cond = 4'h0; it_len = '0; it_mask = '0;
        it_step = 1'b0; it_flush = 1'b0;

        tick();
        @(negedge clk);
        check("reset_sr0", 32'(sr_o0), 32'd0);
        check("reset_sr1", 32'(sr_o1), 32'd0);
        check("reset_qvalid1", 32'(q_valid_o1), 32'd0);
        check("reset_qpass1", 32'(q_pass_o1), 32'd0);
        chk_seq("reset", 1'b0, '0, 1'b1);
        tick();
        rst_n = 1'b1;

        // All 16 conditions: ch0 walks up, ch1 walks down
        set_sr(4'b0110);
        for (int i = 0; i < 16; i++) begin
            query(2'b11, 4'(i), 4'(15 - i), {tab[15 - i], tab[i]});
            tick();
        end
        q_valid_i = '0;
        tick();

        // EQ/NE on Z=1, then an idle cycle, then ch0 invalid with AL
        set_sr(4'b0100);
        query(2'b11, 4'b0000, 4'b0001, 2'b01);
        tick();
        query(2'b00, 4'b1110, 4'b1110, 2'b00);
        tick();
        query(2'b10, 4'b1110, 4'b1110, 2'b10);
        tick();
        q_valid_i = '0;
        tick();

        // Same-cycle SR write with an EQ query
        set_sr(4'b0000);
        sr_we = 1'b1;
        sr_in = 4'b0100;
        query(2'b01, 4'b0000, 4'b0000, {1'b0, fwd_exp});
        tick();
        sr_we = 1'b0;
        q_valid_i = '0;
        @(negedge clk);
        check("fwd_sr_after", 32'(sr_o0), 32'h4);
        tick();

        // Predication block EQ, len 3, then/else/then with Z=1
        it_start = 1'b1; it_cond = 4'b0000; it_len = 3'd3; it_mask = 4'b0101;
        tick();
        it_start = 1'b0;
        @(negedge clk);
        chk_seq("it_slot0", 1'b1, 3'd3, 1'b1);
        it_step = 1'b1;
        tick();
        @(negedge clk);
        chk_seq("it_slot1", 1'b1, 3'd2, 1'b0);
        tick();
        @(negedge clk);
        chk_seq("it_slot2", 1'b1, 3'd1, 1'b1);
        tick();
        it_step = 1'b0;
        @(negedge clk);
        chk_seq("it_done", 1'b0, 3'd0, 1'b1);

        // Flush beats a same-cycle start
        it_start = 1'b1; it_len = 3'd3; it_mask = 4'b0101;
        tick();
        it_start = 1'b0; it_step = 1'b1;
        tick();
        it_step = 1'b0;
        @(negedge clk);
        chk_seq("flush_pre", 1'b1, 3'd2, 1'b0);
        it_flush = 1'b1; it_start = 1'b1; it_len = 3'd2;
        tick();
        it_flush = 1'b0; it_start = 1'b0;
        @(negedge clk);
        chk_seq("flush", 1'b0, 3'd0, 1'b1);
        it_step = 1'b1;
        tick();
        it_step = 1'b0;
        @(negedge clk);
        chk_seq("step_idle", 1'b0, 3'd0, 1'b1);

        // Illegal lengths are ignored
        it_start = 1'b1; it_len = 3'd0;
        tick();
        it_start = 1'b0;
        @(negedge clk);
        chk_seq("len0", 1'b0, 3'd0, 1'b1);
        it_start = 1'b1; it_len = 3'd5;
        tick();
        it_start = 1'b0;
        @(negedge clk);
        chk_seq("len5", 1'b0, 3'd0, 1'b1);

        // Full-length else block, then restart with a same-cycle step
        it_start = 1'b1; it_len = 3'd4; it_mask = 4'b0000;
        tick();
        it_start = 1'b0;
        @(negedge clk);
        chk_seq("len4", 1'b1, 3'd4, 1'b0);
        it_step = 1'b1;
        tick();
        @(negedge clk);
        chk_seq("len4_step", 1'b1, 3'd3, 1'b0);
        it_start = 1'b1; it_len = 3'd2; it_mask = 4'b0011;
        tick();
        it_start = 1'b0; it_step = 1'b0;
        @(negedge clk);
        chk_seq("restart", 1'b1, 3'd2, 1'b1);
        it_step = 1'b1;
        tick();
        it_step = 1'b0;
        @(negedge clk);
        chk_seq("restart_step", 1'b1, 3'd1, 1'b1);

        // Reset mid-block with an in-flight query
        set_sr(4'b1111);
        rst_n = 1'b0;
        q_valid_i = 2'b11;
        q_cond_i  = {4'b1110, 4'b1110};
        tick();
        rst_n = 1'b1;
        q_valid_i = '0;
        @(negedge clk);
        check("rst_mid_sr0", 32'(sr_o0), 32'd0);
        check("rst_mid_sr1", 32'(sr_o1), 32'd0);
        check("rst_mid_qvalid1", 32'(q_valid_o1), 32'd0);
        chk_seq("rst_mid", 1'b0, 3'd0, 1'b1);

        repeat (3) tick();
        check("queue0_empty", 32'(exp_q0.size()), 32'd0);
        check("queue1_empty", 32'(exp_q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
